// File: rtl/mips_mux_pkg.sv
// Shared constants and helpers for the mux_fifo_n selector/queue slice.
// Used by mux_n_comb and mux_fifo_n.
package mips_mux_pkg;

    localparam int   DEFAULT_WIDTH    = 32;
    localparam logic OUT_DATA_RST_BIT = 1'b0;

    // Always at least one bit wide, so a 2-input mux still has a select line.
    function automatic int sel_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_n_comb.sv
// Purely combinational NUM_IN-to-1 word selector; out-of-range selects return channel 0.
// The range flag port exists only when MUX_FIFO_SEL_CHECK_EN is defined.
module mux_n_comb
    import mips_mux_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = sel_clog2(NUM_IN)
) (
    input  logic [NUM_IN*WIDTH-1:0] i_data,
    input  logic [SEL_W-1:0]        i_sel,
`ifdef MUX_FIFO_SEL_CHECK_EN
    output logic                    o_sel_err,
`endif
    output logic [WIDTH-1:0]        o_data
);

    always_comb begin
        o_data = i_data[WIDTH-1:0];
        for (int k = 1; k < NUM_IN; k++) begin
            if (i_sel == SEL_W'(k)) begin
                o_data = i_data[k*WIDTH +: WIDTH];
            end
        end
    end

`ifdef MUX_FIFO_SEL_CHECK_EN
    assign o_sel_err = ({1'b0, i_sel} >= (SEL_W+1)'(NUM_IN));
`endif

endmodule

// File: rtl/mux_fifo_n.sv
// N-channel selector feeding a DEPTH-entry valid/ready queue; async active-high reset.
// Define MUX_FIFO_SEL_CHECK_EN to build the sticky illegal-select flag (else sel_err = 0).
module mux_fifo_n
    import mips_mux_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int NUM_IN = 4,
    parameter int DEPTH  = 4,
    parameter int SEL_W  = sel_clog2(NUM_IN),
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CNT_W-1:0]        count,
    output logic                    sel_err
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic [WIDTH-1:0] w_sel_data;
    logic             w_push;
    logic             w_pop;

`ifdef MUX_FIFO_SEL_CHECK_EN
    logic w_sel_err;
    logic r_sel_err;
`endif

    mux_n_comb #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_mux (
        .i_data    (in_data),
        .i_sel     (in_sel),
`ifdef MUX_FIFO_SEL_CHECK_EN
        .o_sel_err (w_sel_err),
`endif
        .o_data    (w_sel_data)
    );

    // Handshake flags come from the registered count only, never from out_ready.
    assign in_ready  = (r_count != CNT_W'(DEPTH));
    assign out_valid = (r_count != '0);
    assign out_data  = out_valid ? r_mem[r_rd_ptr] : {WIDTH{OUT_DATA_RST_BIT}};
    assign count     = r_count;

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

    // NOTE: storage is deliberately left out of reset; count gates every read of it.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_sel_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef MUX_FIFO_SEL_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sel_err <= 1'b0;
        end else if (w_push && w_sel_err) begin
            r_sel_err <= 1'b1;
        end
    end

    assign sel_err = r_sel_err;
`else
    assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_fifo_n.sv
// Directed self-checking bench for mux_fifo_n: a 4-channel instance and a 3-channel
// instance for the illegal-select path (sel_err expectation follows MUX_FIFO_SEL_CHECK_EN).
module tb_mux_fifo_n;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

`ifdef MUX_FIFO_SEL_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;

    logic [4*WIDTH-1:0] in_data = '0;
    logic [1:0]         in_sel = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [CNT_W-1:0]   count;
    logic               sel_err;

    logic [3*WIDTH-1:0] in_data3 = '0;
    logic [1:0]         in_sel3 = '0;
    logic               in_valid3 = 1'b0;
    logic               in_ready3;
    logic [WIDTH-1:0]   out_data3;
    logic               out_valid3;
    logic               out_ready3 = 1'b0;
    logic [CNT_W-1:0]   count3;
    logic               sel_err3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mux_fifo_n #(.WIDTH(WIDTH), .NUM_IN(4), .DEPTH(DEPTH)) u_dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .count(count), .sel_err(sel_err)
    );

    mux_fifo_n #(.WIDTH(WIDTH), .NUM_IN(3), .DEPTH(DEPTH)) u_dut3 (
        .clk(clk), .reset(reset), .in_data(in_data3), .in_sel(in_sel3),
        .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3),
        .out_valid(out_valid3), .out_ready(out_ready3), .count(count3), .sel_err(sel_err3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push4(input logic [1:0] sel);
        in_sel   = sel;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_q [4];

        in_data = {32'h44, 32'h33, 32'h22, 32'h11};
        step();
        step();
        reset = 1'b0;
        check("rst_count",    32'(count),     32'd0);
        check("rst_valid",    32'(out_valid), 32'd0);
        check("rst_data",     out_data,       32'h0);
        check("rst_in_ready", 32'(in_ready),  32'd1);
        check("rst_sel_err",  32'(sel_err),   32'd0);

        // Reset mid-stream with three entries held
        push4(2'd0);
        push4(2'd1);
        push4(2'd2);
        check("mid_count_before", 32'(count), 32'd3);
        reset = 1'b1;
        #1;
        check("mid_async_count", 32'(count), 32'd0);
        step();
        reset = 1'b0;
        check("mid_count",    32'(count),     32'd0);
        check("mid_valid",    32'(out_valid), 32'd0);
        check("mid_data",     out_data,       32'h0);
        check("mid_in_ready", 32'(in_ready),  32'd1);

        // Single push into empty queue, one-cycle latency
        push4(2'd2);
        check("single_data",  out_data,       32'h33);
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_count", 32'(count),     32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("single_pop_count", 32'(count),     32'd0);
        check("single_pop_valid", 32'(out_valid), 32'd0);
        check("empty_data_zero",  out_data,       32'h0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("empty_pop_ignored", 32'(count), 32'd0);

        // Fill, blocked push while full, then drain in order
        push4(2'd0);
        push4(2'd1);
        push4(2'd3);
        push4(2'd2);
        check("full_count",    32'(count),    32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        in_sel   = 2'd1;
        in_valid = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        check("full_hold_count", 32'(count), 32'd4);
        check("full_hold_data",  out_data,   32'h11);
        exp_q = '{32'h11, 32'h22, 32'h44, 32'h33};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_data_%0d", i), out_data, exp_q[i]);
            check($sformatf("drain_valid_%0d", i), 32'(out_valid), 32'd1);
            step();
        end
        out_ready = 1'b0;
        check("drain_count", 32'(count), 32'd0);

        // Full queue: pop and push offered together, only the pop happens
        push4(2'd0);
        push4(2'd1);
        push4(2'd2);
        push4(2'd3);
        in_sel    = 2'd3;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("fullpop_count",    32'(count),    32'd3);
        check("fullpop_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check("fullpop_push_count", 32'(count), 32'd4);
        exp_q = '{32'h22, 32'h33, 32'h44, 32'h44};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("fullpop_drain_%0d", i), out_data, exp_q[i]);
            step();
        end
        out_ready = 1'b0;
        check("fullpop_drain_count", 32'(count), 32'd0);

        // Streaming: push every cycle, pop every cycle after the first, across pointer wrap
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < 4; k++) begin
                in_data[k*WIDTH +: WIDTH] = 32'h1000 * i + k;
            end
            in_sel    = 2'(i % 4);
            in_valid  = 1'b1;
            out_ready = (i > 0);
            step();
            check($sformatf("stream_count_%0d", i), 32'(count), 32'd1);
            check($sformatf("stream_data_%0d", i), out_data, 32'h1000 * i + (i % 4));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("stream_end_count", 32'(count), 32'd0);

        // Three-channel instance: illegal select writes channel 0
        in_data3  = {32'h33, 32'h22, 32'h11};
        in_sel3   = 2'd3;
        in_valid3 = 1'b1;
        step();
        in_sel3   = 2'd1;
        check("sel3_data",    out_data3,      32'h11);
        check("sel3_err",     32'(sel_err3),  32'(EXP_ERR));
        check("sel3_count",   32'(count3),    32'd1);
        step();
        in_valid3 = 1'b0;
        check("sel3_err_legal_push", 32'(sel_err3), 32'(EXP_ERR));
        out_ready3 = 1'b1;
        step();
        check("sel3_second_data", out_data3, 32'h22);
        step();
        out_ready3 = 1'b0;
        check("sel3_empty_count", 32'(count3),   32'd0);
        check("sel3_err_sticky",  32'(sel_err3), 32'(EXP_ERR));
        check("sel4_err_never",   32'(sel_err),  32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("sel3_err_cleared", 32'(sel_err3), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
